reg_file_stage: RTL and testbench

//  Integer register file: consumer end of the write-back interface (we_rd/rd_addr/rd_data) and

---
 rtl/reg_file_stage.sv | 104 ++++++++++
 tb/tb_reg_file_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_stage.sv
// Integer register file with two registered read ports, write-first bypass from write-back,
// x0 hard-wired to zero, and a post-reset sweep that clears the array before the pipeline runs.
module reg_file_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              rf_clk,
  input  logic              rf_rst,
  input  logic              rf_i_we_rd,
  input  logic [AWIDTH-1:0] rf_i_rd_addr,
  input  logic [DWIDTH-1:0] rf_i_rd_data,
  input  logic              rf_i_ce,
  input  logic              rf_i_stall,
  input  logic              rf_i_flush,
  input  logic [AWIDTH-1:0] rf_i_rs1_addr,
  input  logic [AWIDTH-1:0] rf_i_rs2_addr,
  output logic [DWIDTH-1:0] rf_o_rs1_data,
  output logic [DWIDTH-1:0] rf_o_rs2_data,
  output logic [AWIDTH-1:0] rf_o_rs1_addr,
  output logic [AWIDTH-1:0] rf_o_rs2_addr,
  output logic              rf_o_ce,
  output logic              rf_o_ready,
  output logic              rf_o_stall
);

  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] init_cnt;
  logic [DWIDTH-1:0] regs [DEPTH];
  logic              wb_commit;
  logic [DWIDTH-1:0] rs1_next;
  logic [DWIDTH-1:0] rs2_next;

  assign wb_commit  = (state == ST_RUN) && rf_i_we_rd && (rf_i_rd_addr != '0);
  assign rf_o_stall = ~rf_o_ready;

  // Entry 0 is never stored; the read muxes force it to zero instead.
  always_comb begin
    rs1_next = regs[rf_i_rs1_addr];
    if (rf_i_rs1_addr == '0)
      rs1_next = '0;
    else if (rf_i_we_rd && (rf_i_rd_addr == rf_i_rs1_addr))
      rs1_next = rf_i_rd_data;
  end

  always_comb begin
    rs2_next = regs[rf_i_rs2_addr];
    if (rf_i_rs2_addr == '0)
      rs2_next = '0;
    else if (rf_i_we_rd && (rf_i_rd_addr == rf_i_rs2_addr))
      rs2_next = rf_i_rd_data;
  end

  // Single write port shared by the clearing sweep and write-back commits.
  always_ff @(posedge rf_clk) begin
    if (state == ST_INIT)
      regs[init_cnt] <= '0;
    else if (wb_commit)
      regs[rf_i_rd_addr] <= rf_i_rd_data;
  end

  always_ff @(posedge rf_clk or posedge rf_rst) begin
    if (rf_rst) begin
      state         <= ST_INIT;
      init_cnt      <= AWIDTH'(1);
      rf_o_ready    <= 1'b0;
      rf_o_ce       <= 1'b0;
      rf_o_rs1_data <= '0;
      rf_o_rs2_data <= '0;
      rf_o_rs1_addr <= '0;
      rf_o_rs2_addr <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + AWIDTH'(1);
      if (init_cnt == '1) begin
        state      <= ST_RUN;
        rf_o_ready <= 1'b1;
      end
    end else begin
      // Flush beats stall beats a new capture; stalled outputs stay frozen even if WB rewrites them.
      if (rf_i_flush) begin
        rf_o_ce       <= 1'b0;
        rf_o_rs1_data <= '0;
        rf_o_rs2_data <= '0;
        rf_o_rs1_addr <= '0;
        rf_o_rs2_addr <= '0;
      end else if (!rf_i_stall) begin
        rf_o_ce <= rf_i_ce;
        if (rf_i_ce) begin
          rf_o_rs1_addr <= rf_i_rs1_addr;
          rf_o_rs2_addr <= rf_i_rs2_addr;
          rf_o_rs1_data <= rs1_next;
          rf_o_rs2_data <= rs2_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_stage.sv
// Directed-vector bench for reg_file_stage: init sweep, reads, bypass, x0, stall/flush, mid-run reset.
module tb_reg_file_stage;

  logic        rf_clk;
  logic        rf_rst;
  logic        rf_i_we_rd;
  logic [4:0]  rf_i_rd_addr;
  logic [31:0] rf_i_rd_data;
  logic        rf_i_ce;
  logic        rf_i_stall;
  logic        rf_i_flush;
  logic [4:0]  rf_i_rs1_addr;
  logic [4:0]  rf_i_rs2_addr;
  logic [31:0] rf_o_rs1_data;
  logic [31:0] rf_o_rs2_data;
  logic [4:0]  rf_o_rs1_addr;
  logic [4:0]  rf_o_rs2_addr;
  logic        rf_o_ce;
  logic        rf_o_ready;
  logic        rf_o_stall;

  int n_applied;
  int n_miscompares;

  typedef struct {
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        ce;
    logic        stall;
    logic        flush;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_ce;
    logic [31:0] exp_rs1_data;
    logic [31:0] exp_rs2_data;
    logic [4:0]  exp_rs1_addr;
    logic [4:0]  exp_rs2_addr;
  } vec_t;

  vec_t vectors [13];

  reg_file_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
    .rf_clk        (rf_clk),
    .rf_rst        (rf_rst),
    .rf_i_we_rd    (rf_i_we_rd),
    .rf_i_rd_addr  (rf_i_rd_addr),
    .rf_i_rd_data  (rf_i_rd_data),
    .rf_i_ce       (rf_i_ce),
    .rf_i_stall    (rf_i_stall),
    .rf_i_flush    (rf_i_flush),
    .rf_i_rs1_addr (rf_i_rs1_addr),
    .rf_i_rs2_addr (rf_i_rs2_addr),
    .rf_o_rs1_data (rf_o_rs1_data),
    .rf_o_rs2_data (rf_o_rs2_data),
    .rf_o_rs1_addr (rf_o_rs1_addr),
    .rf_o_rs2_addr (rf_o_rs2_addr),
    .rf_o_ce       (rf_o_ce),
    .rf_o_ready    (rf_o_ready),
    .rf_o_stall    (rf_o_stall)
  );

  initial rf_clk = 1'b0;
  always #5 rf_clk = ~rf_clk;

  task automatic step();
    @(posedge rf_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_applied++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd_addr, input logic [31:0] rd_data,
                       input logic ce, input logic stall, input logic flush,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    rf_i_we_rd    = we;
    rf_i_rd_addr  = rd_addr;
    rf_i_rd_data  = rd_data;
    rf_i_ce       = ce;
    rf_i_stall    = stall;
    rf_i_flush    = flush;
    rf_i_rs1_addr = rs1;
    rf_i_rs2_addr = rs2;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    drive(v.we, v.rd_addr, v.rd_data, v.ce, v.stall, v.flush, v.rs1, v.rs2);
    step();
    check_output($sformatf("vec%0d_ce", idx), 32'(rf_o_ce), 32'(v.exp_ce));
    check_output($sformatf("vec%0d_rs1_data", idx), rf_o_rs1_data, v.exp_rs1_data);
    check_output($sformatf("vec%0d_rs2_data", idx), rf_o_rs2_data, v.exp_rs2_data);
    check_output($sformatf("vec%0d_rs1_addr", idx), 32'(rf_o_rs1_addr), 32'(v.exp_rs1_addr));
    check_output($sformatf("vec%0d_rs2_addr", idx), 32'(rf_o_rs2_addr), 32'(v.exp_rs2_addr));
  endtask

  // Runs the 31-edge clearing sweep, checking the stall flag each edge and ready on the last.
  task automatic run_init(input string tag);
    for (int e = 1; e <= 31; e++) begin
      step();
      check_output($sformatf("%s_ce_edge%0d", tag, e), 32'(rf_o_ce), 32'd0);
      if (e < 31) begin
        check_output($sformatf("%s_stall_edge%0d", tag, e), 32'(rf_o_stall), 32'd1);
      end else begin
        check_output($sformatf("%s_ready_edge31", tag), 32'(rf_o_ready), 32'd1);
        check_output($sformatf("%s_stall_edge31", tag), 32'(rf_o_stall), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_applied     = 0;
    n_miscompares = 0;

    //                we    rd_addr data           ce    stall flush rs1    rs2    e_ce  e_rs1          e_rs2          e_a1   e_a2
    vectors[0]  = '{1'b1, 5'd10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 32'h0,        32'h0,        5'd31, 5'd31};
    vectors[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd10, 5'd0,  1'b1, 32'hDEADBEEF, 32'h0,        5'd10, 5'd0};
    vectors[2]  = '{1'b1, 5'd5,  32'h12345678, 1'b1, 1'b0, 1'b0, 5'd5,  5'd5,  1'b1, 32'h12345678, 32'h12345678, 5'd5,  5'd5};
    vectors[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd5,  5'd10, 1'b1, 32'h12345678, 32'hDEADBEEF, 5'd5,  5'd10};
    vectors[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 32'h0,        32'h0,        5'd0,  5'd0};
    vectors[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  5'd5,  1'b1, 32'h0,        32'h12345678, 5'd0,  5'd5};
    vectors[6]  = '{1'b1, 5'd10, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 5'd10, 5'd5,  1'b1, 32'h0BADF00D, 32'h12345678, 5'd10, 5'd5};
    vectors[7]  = '{1'b1, 5'd3,  32'h33333333, 1'b0, 1'b0, 1'b0, 5'd1,  5'd2,  1'b0, 32'h0BADF00D, 32'h12345678, 5'd10, 5'd5};
    vectors[8]  = '{1'b1, 5'd31, 32'h1F1F1F1F, 1'b1, 1'b0, 1'b0, 5'd3,  5'd10, 1'b1, 32'h33333333, 32'h0BADF00D, 5'd3,  5'd10};
    vectors[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd3,  5'd3,  1'b0, 32'h0,        32'h0,        5'd0,  5'd0};
    vectors[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd31, 5'd31, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0};
    vectors[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd31, 5'd3,  1'b1, 32'h1F1F1F1F, 32'h33333333, 5'd31, 5'd3};
    vectors[12] = '{1'b1, 5'd3,  32'h44444444, 1'b1, 1'b0, 1'b0, 5'd31, 5'd3,  1'b1, 32'h1F1F1F1F, 32'h44444444, 5'd31, 5'd3};

    // Reset for two cycles, then the clearing sweep.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    rf_rst = 1'b1;
    step();
    check_output("rst_ce", 32'(rf_o_ce), 32'd0);
    check_output("rst_rs1_data", rf_o_rs1_data, 32'h0);
    check_output("rst_ready", 32'(rf_o_ready), 32'd0);
    check_output("rst_stall", 32'(rf_o_stall), 32'd1);
    step();
    rf_rst = 1'b0;
    run_init("init");

    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 5'(i), 5'(i));
      step();
      check_output($sformatf("clear_x%0d_rs1", i), rf_o_rs1_data, 32'h0);
      check_output($sformatf("clear_x%0d_rs2", i), rf_o_rs2_data, 32'h0);
      check_output($sformatf("clear_x%0d_addr", i), 32'(rf_o_rs1_addr), 32'(i));
    end

    for (int i = 0; i < 13; i++) apply_stimulus(vectors[i], i);

    // Stall holds a captured value while WB rewrites that register and the address moves.
    drive(1'b1, 5'd7, 32'h77777777, 1'b1, 1'b0, 1'b0, 5'd7, 5'd7);
    step();
    check_output("stall_load_rs1", rf_o_rs1_data, 32'h77777777);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd7, 32'h70000000 + 32'(k), 1'b1, 1'b1, 1'b0, 5'(8 + k), 5'd7);
      step();
      check_output($sformatf("stall%0d_ce", k), 32'(rf_o_ce), 32'd1);
      check_output($sformatf("stall%0d_rs1_data", k), rf_o_rs1_data, 32'h77777777);
      check_output($sformatf("stall%0d_rs2_data", k), rf_o_rs2_data, 32'h77777777);
      check_output($sformatf("stall%0d_rs1_addr", k), 32'(rf_o_rs1_addr), 32'd7);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd7, 5'd7);
    step();
    check_output("flush_stall_ce", 32'(rf_o_ce), 32'd0);
    check_output("flush_stall_rs1_data", rf_o_rs1_data, 32'h0);
    check_output("flush_stall_rs2_data", rf_o_rs2_data, 32'h0);
    check_output("flush_stall_rs1_addr", 32'(rf_o_rs1_addr), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
    step();
    check_output("after_stall_x7", rf_o_rs1_data, 32'h70000002);

    // Mid-run reset: outputs clear at once, sweep reruns, writes during the sweep are dropped.
    drive(1'b1, 5'd7, 32'h000000AA, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd7);
    step();
    check_output("pre_rst_x7", rf_o_rs1_data, 32'h000000AA);
    rf_rst = 1'b1;
    #1;
    check_output("async_rst_ce", 32'(rf_o_ce), 32'd0);
    check_output("async_rst_rs1_data", rf_o_rs1_data, 32'h0);
    check_output("async_rst_rs1_addr", 32'(rf_o_rs1_addr), 32'd0);
    check_output("async_rst_ready", 32'(rf_o_ready), 32'd0);
    check_output("async_rst_stall", 32'(rf_o_stall), 32'd1);
    step();
    drive(1'b1, 5'd9, 32'h99999999, 1'b1, 1'b0, 1'b0, 5'd9, 5'd7);
    rf_rst = 1'b0;
    run_init("reinit");
    drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd9);
    step();
    check_output("reinit_ce", 32'(rf_o_ce), 32'd1);
    check_output("reinit_x7", rf_o_rs1_data, 32'h0);
    check_output("reinit_x9_dropped", rf_o_rs2_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
